fb_bunch_sequencer: RTL and testbench

//  Sequences the multiply/feedforward datapath for a multi-bunch train. On an accepted

---
 rtl/fb_bunch_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_fb_bunch_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_bunch_sequencer.sv
// Multi-bunch feedback sequencer: on an accepted trigger it walks a train of up
// to NBUNCH_MAX bunch strobes, presents a per-bunch coefficient from a small
// register bank to the shared multiplier, gates the feedforward path and tags
// datapath overflow flags with the bunch that caused them.
module fb_bunch_sequencer #(
    parameter int NBUNCH_MAX = 4,
    parameter int CNT_W      = 8,
    parameter int GAIN_W     = 21,
    parameter int MIN_SPACE  = 8,
    parameter int TAIL       = 8,
    localparam int IDX_W     = $clog2(NBUNCH_MAX),
    localparam int NB_W      = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig,
    input  logic [NB_W-1:0]          n_bunches,
    input  logic [CNT_W-1:0]         first_delay,
    input  logic [CNT_W-1:0]         spacing,
    input  logic                     gain_wr_en,
    input  logic [IDX_W-1:0]         gain_wr_addr,
    input  logic signed [GAIN_W-1:0] gain_wr_data,
    input  logic                     dsp_oflow,
    output logic                     store_strb,
    output logic                     bunch_strb,
    output logic                     delay_en,
    output logic signed [GAIN_W-1:0] charge_out,
    output logic [IDX_W-1:0]         bunch_idx,
    output logic                     busy,
    output logic                     done,
    output logic [NBUNCH_MAX-1:0]    oflow_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT,
        S_STROBE,
        S_GAP,
        S_TAIL,
        S_FIN
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [IDX_W-1:0]          n_last, n_last_nxt;
    logic [CNT_W-1:0]          sp_eff, sp_eff_nxt;
    logic [IDX_W-1:0]          idx_nxt;
    logic [NBUNCH_MAX-1:0]     flags_nxt;
    logic                      delay_nxt;
    logic [NB_W-1:0]           n_clamped;
    logic [IDX_W-1:0]          n_last_in;
    logic [CNT_W-1:0]          sp_in;
    logic signed [GAIN_W-1:0]  bank [NBUNCH_MAX];

    // Clamp the requested bunch count into 1..NBUNCH_MAX at the trigger input.
    always_comb begin
        n_clamped = n_bunches;
        if (n_bunches == '0) begin
            n_clamped = NB_W'(1);
        end else if (n_bunches > NB_W'(NBUNCH_MAX)) begin
            n_clamped = NB_W'(NBUNCH_MAX);
        end
    end

    // Train stores the index of its last bunch; spacing is floored to the datapath minimum.
    assign n_last_in = IDX_W'(n_clamped - NB_W'(1));
    assign sp_in     = (spacing < CNT_W'(MIN_SPACE)) ? CNT_W'(MIN_SPACE) : spacing;

    // Coefficient bank: written at any time, read only when a strobe is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the bank is only NBUNCH_MAX words and must read 0 after reset,
            // so it is built from flops and cleared like any other register.
            for (int i = 0; i < NBUNCH_MAX; i++) begin
                bank[i] <= '0;
            end
        end else if (gain_wr_en) begin
            bank[gain_wr_addr] <= gain_wr_data;
        end
    end

    // Next-state and next-register values for the train sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt  = state;
        cnt_nxt    = cnt;
        n_last_nxt = n_last;
        sp_eff_nxt = sp_eff;
        idx_nxt    = bunch_idx;
        flags_nxt  = oflow_flags;
        delay_nxt  = delay_en;

        if (state != S_IDLE && !arm) begin
            // Arm loss aborts immediately and wins over a same-cycle trigger.
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (trig) begin
                        n_last_nxt = n_last_in;
                        sp_eff_nxt = sp_in;
                        idx_nxt    = '0;
                        flags_nxt  = '0;
                        if (first_delay == '0) begin
                            state_nxt = S_STROBE;
                        end else begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = first_delay - CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state_nxt = S_STROBE;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
                S_STROBE: begin
                    if (bunch_idx == n_last) begin
                        state_nxt = S_TAIL;
                        cnt_nxt   = CNT_W'(TAIL - 1);
                    end else begin
                        // Two cycles of the period are spent in STROBE and the last GAP count.
                        state_nxt = S_GAP;
                        cnt_nxt   = sp_eff - CNT_W'(2);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state_nxt = S_STROBE;
                        idx_nxt   = bunch_idx + IDX_W'(1);
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                S_TAIL: begin
                    if (cnt == '0) state_nxt = S_FIN;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
                S_FIN: begin
                    state_nxt = arm ? S_ARMED : S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        // Overflows seen after a strobe belong to the bunch just processed.
        if ((state == S_GAP || state == S_TAIL) && dsp_oflow) begin
            flags_nxt[bunch_idx] = 1'b1;
        end

        // Feedforward is enabled from the second bunch on and held between strobes.
        if (state_nxt == S_STROBE) begin
            delay_nxt = (idx_nxt != '0);
        end else if (state_nxt == S_IDLE || state_nxt == S_ARMED || state_nxt == S_FIN) begin
            delay_nxt = 1'b0;
        end
    end

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            n_last      <= '0;
            sp_eff      <= '0;
            store_strb  <= 1'b0;
            bunch_strb  <= 1'b0;
            delay_en    <= 1'b0;
            charge_out  <= '0;
            bunch_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            oflow_flags <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the
            // pre-edge values, independent of statement order.
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            n_last      <= n_last_nxt;
            sp_eff      <= sp_eff_nxt;
            store_strb  <= (state_nxt != S_IDLE);
            bunch_strb  <= (state_nxt == S_STROBE);
            delay_en    <= delay_nxt;
            bunch_idx   <= idx_nxt;
            busy        <= (state_nxt == S_WAIT) || (state_nxt == S_STROBE) ||
                           (state_nxt == S_GAP)  || (state_nxt == S_TAIL);
            done        <= (state_nxt == S_FIN);
            oflow_flags <= flags_nxt;
            // Coefficient is captured as the strobe launches and held until the next one.
            if (state_nxt == S_STROBE) begin
                charge_out <= bank[idx_nxt];
            end
        end
    end

endmodule

// File: tb/tb_fb_bunch_sequencer.sv
// Scoreboard bench for fb_bunch_sequencer: directed trains push expected strobe
// and done events; a negedge monitor pops and compares whenever one appears.
module tb_fb_bunch_sequencer;

    localparam int NB = 4;
    localparam int CW = 8;
    localparam int GW = 21;
    localparam int MS = 8;
    localparam int TL = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 arm;
    logic                 trig;
    logic [2:0]           n_bunches;
    logic [CW-1:0]        first_delay;
    logic [CW-1:0]        spacing;
    logic                 gain_wr_en;
    logic [1:0]           gain_wr_addr;
    logic signed [GW-1:0] gain_wr_data;
    logic                 dsp_oflow;
    logic                 store_strb;
    logic                 bunch_strb;
    logic                 delay_en;
    logic signed [GW-1:0] charge_out;
    logic [1:0]           bunch_idx;
    logic                 busy;
    logic                 done;
    logic [NB-1:0]        oflow_flags;

    fb_bunch_sequencer dut (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .n_bunches(n_bunches),
        .first_delay(first_delay), .spacing(spacing), .gain_wr_en(gain_wr_en),
        .gain_wr_addr(gain_wr_addr), .gain_wr_data(gain_wr_data), .dsp_oflow(dsp_oflow),
        .store_strb(store_strb), .bunch_strb(bunch_strb), .delay_en(delay_en),
        .charge_out(charge_out), .bunch_idx(bunch_idx), .busy(busy), .done(done),
        .oflow_flags(oflow_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                   is_done;
        int                   cyc;
        logic signed [GW-1:0] charge;
        logic [1:0]           idx;
        logic                 den;
    } exp_t;

    exp_t                 q[$];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    logic signed [GW-1:0] model_bank [NB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every strobe or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (bunch_strb || done)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event @cyc %0d: strb=%0b done=%0b with nothing expected",
                         cyc, bunch_strb, done);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind_done", 64'(done), 64'(e.is_done));
                check("event_cycle", 64'(cyc), 64'(e.cyc));
                check("store_strb_during_train", 64'(store_strb), 64'd1);
                if (!e.is_done) begin
                    check("charge_out", 64'(charge_out), 64'(e.charge));
                    check("bunch_idx", 64'(bunch_idx), 64'(e.idx));
                    check("delay_en_at_strobe", 64'(delay_en), 64'(e.den));
                    check("busy_at_strobe", 64'(busy), 64'd1);
                end else begin
                    check("busy_at_done", 64'(busy), 64'd0);
                    check("delay_en_at_done", 64'(delay_en), 64'd0);
                end
            end
        end
    end

    task automatic write_gain(input int a, input int d);
        @(negedge clk);
        gain_wr_en   = 1'b1;
        gain_wr_addr = 2'(a);
        gain_wr_data = GW'(d);
        @(negedge clk);
        gain_wr_en   = 1'b0;
        model_bank[a] = GW'(d);
    endtask

    // Issue one trigger and push the expected strobes (up to npush) and done.
    task automatic fire(input int n, input int fd, input int sp, input int npush,
                        input bit push_done, output int c);
        int ne, se;
        ne = (n < 1) ? 1 : ((n > NB) ? NB : n);
        se = (sp < MS) ? MS : sp;
        @(negedge clk);
        c           = cyc;
        n_bunches   = 3'(n);
        first_delay = CW'(fd);
        spacing     = CW'(sp);
        trig        = 1'b1;
        for (int k = 0; k < ne && k < npush; k++) begin
            exp_t e;
            e.is_done = 1'b0;
            e.cyc     = c + 1 + fd + k * se;
            e.charge  = model_bank[k];
            e.idx     = 2'(k);
            e.den     = (k > 0);
            q.push_back(e);
        end
        if (push_done) begin
            exp_t e;
            e.is_done = 1'b1;
            e.cyc     = c + 1 + fd + (ne - 1) * se + TL + 1;
            e.charge  = '0;
            e.idx     = '0;
            e.den     = 1'b0;
            q.push_back(e);
        end
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout @cyc %0d: %0d events outstanding, required 0", cyc, q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; arm = 1'b0; trig = 1'b0; n_bunches = '0; first_delay = '0;
        spacing = '0; gain_wr_en = 1'b0; gain_wr_addr = '0; gain_wr_data = '0;
        dsp_oflow = 1'b0;
        for (int i = 0; i < NB; i++) model_bank[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_store_strb", 64'(store_strb), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_charge_out", 64'(charge_out), 64'd0);
        check("rst_flags", 64'(oflow_flags), 64'd0);
        rst = 1'b0;

        // Trigger while disarmed must be ignored.
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        check("idle_trig_busy", 64'(busy), 64'd0);
        check("idle_store_strb", 64'(store_strb), 64'd0);

        write_gain(0, 100);
        write_gain(1, -200);
        write_gain(2, 300);
        write_gain(3, -400);
        arm = 1'b1;
        repeat (2) @(negedge clk);
        check("armed_store_strb", 64'(store_strb), 64'd1);
        check("armed_busy", 64'(busy), 64'd0);

        // 1) single bunch, first_delay 3
        fire(1, 3, 10, 4, 1'b1, c);
        wait_drain(100);
        // 2) four bunches, spacing 10
        fire(4, 2, 10, 4, 1'b1, c);
        wait_drain(200);
        // 3) spacing clamp, zero and oversize bunch counts
        fire(2, 0, 3, 4, 1'b1, c);
        wait_drain(100);
        fire(0, 1, 20, 4, 1'b1, c);
        wait_drain(100);
        fire(7, 0, 8, 4, 1'b1, c);
        wait_drain(200);

        // 4) overflow two cycles after the third strobe
        fire(4, 0, 10, 4, 1'b1, c);
        wait_cyc(c + 1 + 2 * 10 + 2);
        dsp_oflow = 1'b1;
        @(negedge clk);
        dsp_oflow = 1'b0;
        wait_drain(200);
        check("oflow_flags_bunch2", 64'(oflow_flags), 64'b0100);
        fire(1, 5, 8, 4, 1'b1, c);
        check("oflow_cleared_on_trig", 64'(oflow_flags), 64'd0);
        wait_drain(100);

        // 5) abort in GAP after the second strobe, with a mid-train trigger
        fire(4, 0, 10, 2, 1'b0, c);
        wait_cyc(c + 3);
        dsp_oflow = 1'b1;
        @(negedge clk);
        dsp_oflow = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        wait_cyc(c + 1 + 10 + 2);
        arm = 1'b0;
        @(negedge clk);
        check("abort_store_strb", 64'(store_strb), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_delay_en", 64'(delay_en), 64'd0);
        check("abort_flags_kept", 64'(oflow_flags), 64'b0001);
        repeat (40) @(negedge clk);
        check("abort_no_pending", 64'(q.size()), 64'd0);
        arm = 1'b1;
        repeat (2) @(negedge clk);

        // 6) reset during WAIT, then bank reads zero and same-cycle write
        fire(1, 20, 8, 0, 1'b0, c);
        wait_cyc(c + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_store_strb", 64'(store_strb), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_charge", 64'(charge_out), 64'd0);
        check("mid_rst_idx", 64'(bunch_idx), 64'd0);
        check("mid_rst_delay_en", 64'(delay_en), 64'd0);
        for (int i = 0; i < NB; i++) model_bank[i] = '0;
        repeat (2) @(negedge clk);
        fire(2, 0, 8, 4, 1'b1, c);
        // Now inside the first STROBE cycle: overwrite the address being read.
        gain_wr_en   = 1'b1;
        gain_wr_addr = 2'd0;
        gain_wr_data = GW'(555);
        @(negedge clk);
        gain_wr_en = 1'b0;
        model_bank[0] = GW'(555);
        check("same_cycle_write_old_held", 64'(charge_out), 64'd0);
        wait_drain(100);
        fire(1, 0, 8, 4, 1'b1, c);
        wait_drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
